// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 host-port interface sequencer.
// The package is the same in every build; arbitration policy is chosen by the
// HPI_RR_EN macro inside hpi_arb2.
package hpi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } hpi_state_t;

    localparam int HPI_DW = 16;

    // HPI register selects driven onto OTG_ADDR
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_arb2.sv
// Two-way combinational arbiter for the HPI sequencer.
// Build option HPI_RR_EN: when defined, a tie goes to the port that did not
// own the last transaction (round robin); when undefined, port 0 always wins
// a tie. A lone request is always granted. grant is only meaningful while
// valid is high.
module hpi_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

`ifndef HPI_RR_EN
    // Fixed priority ignores history; kept as a port so both builds share a footprint.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner from the current requests (and history when round robin).
    always_comb begin
        valid = req0 | req1;
`ifdef HPI_RR_EN
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = ~req0;
        end
`else
        grant = ~req0;
`endif
    end

endmodule

// File: rtl/hpi_bus_sequencer.sv
// Shares the CY7C67200 HPI pins between port 0 (Nios PIO bridge) and port 1
// (keyboard/mouse poller). Each transaction runs IDLE -> SETUP -> STROBE ->
// HOLD -> RECOVER with cycle counts set by the parameters (legal 1..15).
// Build option HPI_RR_EN selects round-robin arbitration in hpi_arb2.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// them until ackN pulses for one cycle (the HOLD cycle). The command is
// latched when the sequencer leaves IDLE, so later input changes, including
// dropping req, do not affect the launched transaction. rdataN is valid from
// the ack cycle and holds until the next read for that port completes.
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 3,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        addr0,
    input  logic [1:0]        addr1,
    input  logic [HPI_DW-1:0] wdata0,
    input  logic [HPI_DW-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [HPI_DW-1:0] rdata0,
    output logic [HPI_DW-1:0] rdata1,
    output logic              busy,
    output logic              grant,
    output logic [1:0]        hpi_addr,
    output logic              hpi_cs_n,
    output logic              hpi_rd_n,
    output logic              hpi_wr_n,
    input  logic [HPI_DW-1:0] hpi_data_in,
    output logic [HPI_DW-1:0] hpi_data_out,
    output logic              hpi_data_oe,
    output logic [2:0]        dbg_state
);

    // Counters hold "cycles remaining minus one" so the phase ends at zero.
    localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    hpi_state_t        state;
    hpi_state_t        state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              capture;
    logic              rd_sample;
    logic              active;
    logic              arb_grant;
    logic              arb_valid;
    logic              lat_we;
    logic [1:0]        lat_addr;
    logic [HPI_DW-1:0] lat_wdata;

    hpi_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign dbg_state = state;

    // State and phase counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: each timed phase counts down to zero, then loads the next phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_nxt = RECOVER;
                cnt_nxt   = RECOVER_LOAD;
            end
            RECOVER: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Read data is taken at the end of the strobe so the chip has the full pulse to drive it.
    assign rd_sample = (state == STROBE) && (cnt == 4'd0) && !lat_we;

    // Command latch, owner record and per-port read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grant     <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= HPI_DATA;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (capture) begin
                grant     <= arb_grant;
                lat_we    <= arb_grant ? we1 : we0;
                lat_addr  <= arb_grant ? addr1 : addr0;
                lat_wdata <= arb_grant ? wdata1 : wdata0;
            end
            if (rd_sample) begin
                if (grant) begin
                    rdata1 <= hpi_data_in;
                end else begin
                    rdata0 <= hpi_data_in;
                end
            end
        end
    end

    // Pin decode from registered state only, so the HPI pins never see arbiter glitches.
    always_comb begin
        active       = (state == SETUP) || (state == STROBE) || (state == HOLD);
        hpi_cs_n     = !active;
        hpi_rd_n     = !((state == STROBE) && !lat_we);
        hpi_wr_n     = !((state == STROBE) && lat_we);
        hpi_addr     = active ? lat_addr : HPI_DATA;
        hpi_data_oe  = active && lat_we;
        hpi_data_out = (active && lat_we) ? lat_wdata : '0;
        ack0         = (state == HOLD) && !grant;
        ack1         = (state == HOLD) && grant;
        busy         = (state != IDLE);
    end

endmodule
